// File: rtl/srv32_mem_arbiter.sv
// srv32_mem_arbiter: shares one memory bus between fetch, load and store, routing read data back in order.
// Define SRV32_ARB_STARVE_EN to promote a fetch that has waited STARVE_LIMIT cycles.
module srv32_mem_arbiter #(
    parameter int OUTSTANDING  = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        imem_ready,
    input  logic [31:0] imem_addr,
    output logic        imem_valid,
    output logic        imem_rresp,
    output logic [31:0] imem_rdata,
    input  logic        dmem_rready,
    input  logic [31:0] dmem_raddr,
    output logic        dmem_rvalid,
    output logic        dmem_rresp,
    output logic [31:0] dmem_rdata,
    input  logic        dmem_wready,
    input  logic [31:0] dmem_waddr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic        dmem_wvalid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_err
);
    typedef enum logic {IDLE, HOLD} state_t;
    typedef enum logic [1:0] {SRC_F, SRC_L, SRC_S} src_t;

    state_t      state, state_n;
    src_t        src, src_n;
    logic        fifo [0:3];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count, count_n;
    logic [31:0] irdata_q, drdata_q;
    logic        ack, push, pop, head, rd_ok, f_ok, l_ok, s_ok, can_sel, sel, promote;

    assign ack         = state == HOLD && mem_ack;
    assign imem_valid  = ack && src == SRC_F;
    assign dmem_rvalid = ack && src == SRC_L;
    assign dmem_wvalid = ack && src == SRC_S;
    assign mem_req     = state == HOLD;

    assign push    = imem_valid || dmem_rvalid;
    assign pop     = mem_rvalid && count != 3'd0;
    assign head    = fifo[rd_ptr];
    assign count_n = count + {2'b0, push} - {2'b0, pop};

    // Eligibility looks at the count after this cycle's push/pop so a back-to-back pick never overfills the FIFO.
    assign rd_ok   = count_n != 3'(OUTSTANDING);
    assign f_ok    = imem_ready && rd_ok;
    assign l_ok    = dmem_rready && rd_ok;
    assign s_ok    = dmem_wready;
    assign can_sel = state == IDLE || mem_ack;
    assign sel     = can_sel && (f_ok || l_ok || s_ok);

    assign imem_rresp = pop && !head;
    assign dmem_rresp = pop && head;
    assign imem_rdata = imem_rresp ? mem_rdata : irdata_q;
    assign dmem_rdata = dmem_rresp ? mem_rdata : drdata_q;
    assign rsp_err    = resetb && mem_rvalid && count == 3'd0;

    always_comb begin
        state_n = state;
        src_n   = src;
        if (can_sel) begin
            state_n = sel ? HOLD : IDLE;
            src_n   = promote && f_ok ? SRC_F : s_ok ? SRC_S : l_ok ? SRC_L : f_ok ? SRC_F : src;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state <= IDLE;
            src   <= SRC_F;
        end else begin
            state <= state_n;
            src   <= src_n;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else if (sel) begin
            mem_we    <= src_n == SRC_S;
            mem_addr  <= src_n == SRC_S ? dmem_waddr : src_n == SRC_L ? dmem_raddr : imem_addr;
            mem_wdata <= src_n == SRC_S ? dmem_wdata : '0;
            mem_wstrb <= src_n == SRC_S ? dmem_wstrb : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= src == SRC_L;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            count <= count_n;
            if (push) wr_ptr <= wr_ptr == 2'(OUTSTANDING - 1) ? 2'd0 : wr_ptr + 2'd1;
            if (pop) rd_ptr <= rd_ptr == 2'(OUTSTANDING - 1) ? 2'd0 : rd_ptr + 2'd1;
            if (imem_rresp) irdata_q <= mem_rdata;
            if (dmem_rresp) drdata_q <= mem_rdata;
        end
    end

`ifdef SRV32_ARB_STARVE_EN
    logic [7:0] starve;
    assign promote = starve >= 8'(STARVE_LIMIT);
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) starve <= '0;
        else if (imem_valid) starve <= '0;
        else if (f_ok && !(sel && src_n == SRC_F) && !(state == HOLD && src == SRC_F) && starve != 8'hFF)
            starve <= starve + 8'd1;
    end
`else
    logic unused_limit;
    assign unused_limit = ^8'(STARVE_LIMIT);
    assign promote      = 1'b0;
`endif
endmodule

// File: doc/srv32_mem_arbiter.md
SRV32_MEM_ARBITER -- requirements
Module: srv32_mem_arbiter

Interface
REQ-001 The block SHALL have parameter OUTSTANDING, default 2, giving the maximum number of reads in flight (legal 1..4).
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 8, giving the number of wait cycles after which an instruction fetch is promoted (legal 1..255).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock
- resetb  in  1  asynchronous active-low reset
- imem_ready  in  1  fetch request
- imem_addr  in  32  fetch address
- imem_valid  out  1  fetch accepted
- imem_rresp  out  1  fetch data valid
- imem_rdata  out  32  fetch data
- dmem_rready  in  1  load request
- dmem_raddr  in  32  load address
- dmem_rvalid  out  1  load accepted
- dmem_rresp  out  1  load data valid
- dmem_rdata  out  32  load data
- dmem_wready  in  1  store request
- dmem_waddr  in  32  store address
- dmem_wdata  in  32  store data
- dmem_wstrb  in  4  store byte strobes
- dmem_wvalid  out  1  store accepted
- mem_req  out  1  unified bus request
- mem_we  out  1  1 = write
- mem_addr  out  32  bus address
- mem_wdata  out  32  bus write data
- mem_wstrb  out  4  bus strobes; 4'b0000 on reads
- mem_ack  in  1  bus accepted the request this cycle
- mem_rvalid  in  1  read data valid, in request order
- mem_rdata  in  32  read data
- rsp_err  out  1  one-cycle pulse: mem_rvalid arrived with no read outstanding

Function
REQ-005 The block SHALL have states IDLE and HOLD. IDLE moves to HOLD when a source is selected. HOLD moves to IDLE on mem_ack.
REQ-006 In HOLD, mem_req SHALL be 1. mem_we, mem_addr, mem_wdata and mem_wstrb SHALL stay stable until mem_ack, whatever the requesters do.
REQ-007 Selection SHALL happen in IDLE, or in HOLD in the same cycle as mem_ack (back-to-back, no bubble). It SHALL be registered: mem_req rises the cycle after the request is first seen.
REQ-008 Default priority SHALL be store > load > fetch.
REQ-009 Load and fetch SHALL be ineligible while the outstanding count equals OUTSTANDING. Stores remain eligible.
REQ-010 imem_valid, dmem_rvalid and dmem_wvalid SHALL equal mem_ack gated by HOLD and by the held source: combinational, exactly one cycle.
REQ-011 On a read acknowledge, the block SHALL push the source ID (fetch or load) into an in-order FIFO of depth OUTSTANDING.
REQ-012 On mem_rvalid, the block SHALL pop the FIFO head and drive the matching rresp=1 and rdata=mem_rdata in the same cycle. The other rresp SHALL be 0 and the other rdata SHALL hold its value.
REQ-013 Push and pop in the same cycle SHALL leave the count unchanged. The FIFO pointers SHALL wrap modulo OUTSTANDING.
REQ-014 mem_rvalid with an empty FIFO SHALL be dropped: no rresp, and rsp_err=1 for that cycle.
REQ-015 A requester that deasserts before acknowledge while in HOLD SHALL still complete. The requester owns that hazard.

Reset
REQ-016 While resetb=0, the block SHALL reset asynchronously to IDLE, empty FIFO, and starvation counter 0.
REQ-017 While resetb=0, every output SHALL be 0, including rdata, mem_addr, mem_wdata and mem_wstrb.
REQ-018 After reset, responses to reads issued before reset SHALL be treated per REQ-014.

Configuration
REQ-019 With macro SRV32_ARB_STARVE_EN defined, an 8-bit counter SHALL count cycles in which fetch is requested, eligible and not selected.
REQ-020 When that counter reaches STARVE_LIMIT, fetch SHALL take top priority for the next selection. The counter SHALL clear when fetch is acknowledged.
REQ-021 Without SRV32_ARB_STARVE_EN, the counter SHALL not exist and priority SHALL be fixed per REQ-008.

Verification
REQ-022 Scenario: fetch 0x100 alone with mem_ack next cycle and mem_rvalid two cycles later, data 0xDEADBEEF. Required: imem_valid one pulse, then imem_rresp=1 with imem_rdata=0xDEADBEEF; dmem_rresp stays 0.
REQ-023 Scenario: store 0x200 (strb 4'hF), load 0x204 and fetch 0x0 all raised together, mem_ack tied to 1. Required: bus order store, load, fetch on consecutive cycles; mem_wstrb=4'h0 on the two reads.
REQ-024 Scenario: OUTSTANDING=2, two loads acknowledged, no rvalid yet, then fetch plus store requested. Required: store is granted and fetch waits until the first mem_rvalid.
REQ-025 Scenario: load acknowledged in the same cycle as mem_rvalid for an earlier fetch. Required: imem_rresp=1 and the count stays 1; a following rvalid goes to dmem_rresp.
REQ-026 Scenario: mem_rvalid with nothing outstanding. Required: rsp_err pulses once and no rresp is asserted.
REQ-027 Scenario: SRV32_ARB_STARVE_EN defined, STARVE_LIMIT=3, stores continuous and fetch held. Required: fetch is granted at the selection following its third waiting cycle.
